// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: shares one synchronous single-port RAM between a never-stalled
// VGA read port (3-cycle latency) and a buffered PPU write port.
module fb_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vga_req,
    input  logic [ADDR_W-1:0]             vga_addr,
    output logic [DATA_W-1:0]             vga_data,
    output logic                          vga_valid,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic                          ram_we,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          wr_overrun
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {GNT_IDLE, GNT_VGA, GNT_WR} grant_e;

    grant_e              grant;
    logic                push, pop;

    logic [ADDR_W-1:0]   addr_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   addr_mem_d [FIFO_DEPTH];
    logic [DATA_W-1:0]   data_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   data_mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [1:0]          rd_pipe_q, rd_pipe_d;
    logic                vga_valid_q, vga_valid_d;
    logic [DATA_W-1:0]   vga_data_q, vga_data_d;
    logic                overrun_q, overrun_d;

    assign wr_ready   = (level_q != FULL_LVL);
    assign fifo_level = level_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign vga_valid  = vga_valid_q;
    assign vga_data   = vga_data_q;
    assign wr_overrun = overrun_q;

    always_comb begin
        addr_mem_d  = addr_mem_q;
        data_mem_d  = data_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        vga_data_d  = vga_data_q;
        overrun_d   = overrun_q | (wr_valid & ~wr_ready);

        // Grant uses registered occupancy only, so a just-accepted entry waits a cycle.
        if (vga_req)
            grant = GNT_VGA;
        else if (level_q != '0)
            grant = GNT_WR;
        else
            grant = GNT_IDLE;

        push = wr_valid & wr_ready;
        pop  = (grant == GNT_WR);

        case (grant)
            GNT_VGA: ram_addr_d = vga_addr;
            GNT_WR: begin
                ram_addr_d  = addr_mem_q[rd_ptr_q];
                ram_wdata_d = data_mem_q[rd_ptr_q];
                ram_we_d    = 1'b1;
            end
            default: ;
        endcase

        if (push) begin
            addr_mem_d[wr_ptr_q] = wr_addr;
            data_mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Stage 0: address registered; stage 1: RAM read; stage 2: data captured.
        rd_pipe_d   = {rd_pipe_q[0], vga_req};
        vga_valid_d = rd_pipe_q[1];
        if (rd_pipe_q[1])
            vga_data_d = ram_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_mem_q  <= '{default: '0};
            data_mem_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            rd_pipe_q   <= '0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            addr_mem_q  <= addr_mem_d;
            data_mem_q  <= data_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rd_pipe_q   <= rd_pipe_d;
            vga_valid_q <= vga_valid_d;
            vga_data_q  <= vga_data_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural synchronous-read RAM and a
// negedge monitor logging every RAM write.
module tb_fb_arbiter;

    logic        clk;
    logic        rst;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [11:0] vga_data;
    logic        vga_valid;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;
    logic [2:0]  fifo_level;
    logic        wr_overrun;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [11:0] mem [65536];
    logic [27:0] wlog [$];

    fb_arbiter #(.ADDR_W(16), .DATA_W(12), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .fifo_level(fifo_level), .wr_overrun(wr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we) wlog.push_back({ram_addr, ram_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int unsigned cnt;
        int unsigned cyc;
        logic        req_t;

        for (int i = 0; i < 65536; i++) mem[i] = '0;
        ram_rdata = '0;
        rst = 1'b0; vga_req = 1'b0; vga_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state
        tick(); tick();
        check("rst_level", fifo_level, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_valid", vga_valid, 0);
        check("rst_vdata", vga_data, 0);
        check("rst_ovr", wr_overrun, 0);
        rst = 1'b1;
        tick();

        // Write-then-read
        wr_valid = 1'b1; wr_addr = 16'h0010; wr_data = 12'hABC;
        tick();
        wr_valid = 1'b0;
        check("wtr_level1", fifo_level, 1);
        check("wtr_nobypass", ram_we, 0);
        tick();
        check("wtr_we", ram_we, 1);
        check("wtr_addr", ram_addr, 16'h0010);
        check("wtr_wdata", ram_wdata, 12'hABC);
        check("wtr_level0", fifo_level, 0);
        tick();
        check("wtr_we_off", ram_we, 0);
        tick();
        vga_req = 1'b1; vga_addr = 16'h0010;
        tick();
        vga_req = 1'b0;
        check("rd_addr", ram_addr, 16'h0010);
        check("rd_we", ram_we, 0);
        tick();
        check("rd_valid_n2", vga_valid, 0);
        tick();
        check("rd_valid_n3", vga_valid, 1);
        check("rd_data", vga_data, 12'hABC);
        tick();
        check("rd_valid_n4", vga_valid, 0);
        check("rd_data_hold", vga_data, 12'hABC);

        // Priority: VGA held for 10 cycles with one buffered entry
        vga_req = 1'b1; vga_addr = 16'h0020;
        wr_valid = 1'b1; wr_addr = 16'h0030; wr_data = 12'h123;
        tick();
        wr_valid = 1'b0;
        check("prio_level", fifo_level, 1);
        check("prio_we_c1", ram_we, 0);
        for (int k = 2; k <= 10; k++) begin
            tick();
            check($sformatf("prio_we_c%0d", k), ram_we, 0);
        end
        check("prio_level_held", fifo_level, 1);
        check("prio_b2b_valid", vga_valid, 1);
        check("prio_b2b_data", vga_data, 0);
        vga_req = 1'b0;
        tick();
        check("prio_we", ram_we, 1);
        check("prio_addr", ram_addr, 16'h0030);
        check("prio_wdata", ram_wdata, 12'h123);
        check("prio_level0", fifo_level, 0);
        tick(); tick(); tick();
        check("prio_valid_off", vga_valid, 0);

        // Full FIFO under continuous VGA requests
        vga_req = 1'b1; vga_addr = 16'h0020;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_addr = 16'h0040 + 16'(i); wr_data = 12'h500 + 12'(i);
            check($sformatf("full_ready_%0d", i), wr_ready, (i < 4) ? 1 : 0);
            tick();
            if (i == 3) check("full_ovr_before", wr_overrun, 0);
        end
        wr_valid = 1'b0;
        check("full_level", fifo_level, 4);
        check("full_ovr", wr_overrun, 1);
        check("full_we", ram_we, 0);
        tick();
        check("full_ready_held", wr_ready, 0);
        vga_req = 1'b0;
        check("full_ready_popcycle", wr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("drain_we_%0d", i), ram_we, 1);
            check($sformatf("drain_addr_%0d", i), ram_addr, 16'h0040 + i);
            check($sformatf("drain_wdata_%0d", i), ram_wdata, 12'h500 + i);
            check($sformatf("drain_level_%0d", i), fifo_level, 3 - i);
            if (i == 0) check("drain_ready", wr_ready, 1);
        end
        tick();
        check("drain_we_off", ram_we, 0);
        check("full_ovr_sticky", wr_overrun, 1);

        // Order and wrap: 12 writes with alternate-cycle VGA requests
        tick();
        wlog.delete();
        cnt = 0; cyc = 0; req_t = 1'b0;
        while (cnt < 12 && cyc < 200) begin
            wr_valid = wr_ready;
            wr_addr  = 16'(cnt);
            wr_data  = 12'h600 + 12'(cnt);
            vga_req  = req_t; vga_addr = 16'h0100;
            if (wr_ready) cnt++;
            tick();
            req_t = ~req_t;
            cyc++;
        end
        wr_valid = 1'b0; vga_req = 1'b0;
        check("wrap_accepted", cnt, 12);
        cyc = 0;
        while (fifo_level != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("wrap_level0", fifo_level, 0);
        tick(); tick();
        check("wrap_count", wlog.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < wlog.size())
                check($sformatf("wrap_entry_%0d", i), wlog[i], {16'(i), 12'(12'h600 + i)});
        end

        // Mid-operation reset
        check("mrst_ovr_before", wr_overrun, 1);
        vga_req = 1'b1; vga_addr = 16'h0300;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 16'h0200 + 16'(i); wr_data = 12'h700 + 12'(i);
            tick();
        end
        check("mrst_level3", fifo_level, 3);
        rst = 1'b0; vga_req = 1'b0; wr_valid = 1'b0;
        tick();
        rst = 1'b1;
        check("mrst_level", fifo_level, 0);
        check("mrst_ready", wr_ready, 1);
        check("mrst_valid", vga_valid, 0);
        check("mrst_we", ram_we, 0);
        check("mrst_ovr", wr_overrun, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("mrst_post_we_%0d", k), ram_we, 0);
            check($sformatf("mrst_post_valid_%0d", k), vga_valid, 0);
        end
        check("mrst_post_level", fifo_level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
